// File: rtl/pci_target_seq_pkg.sv
// rtl/pci_target_seq_pkg.sv - shared PCI command and target-sequencer state encodings
package pci_target_seq_pkg;

    localparam logic [3:0] CMD_CFG_RD = 4'b1010;
    localparam logic [3:0] CMD_CFG_WR = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_XFER   = 3'd2,
        ST_STOP   = 3'd3,
        ST_TURNAR = 3'd4,
        ST_BUSY   = 3'd5
    } state_t;

    function automatic logic is_cfg_cmd(input logic [3:0] c);
        return (c == CMD_CFG_RD) || (c == CMD_CFG_WR);
    endfunction

endpackage

// File: rtl/pci_target_seq.sv
// rtl/pci_target_seq.sv - PCI target bus sequencer: medium decode, data phases, retry and turnaround
module pci_target_seq
    import pci_target_seq_pkg::*;
#(
    parameter int RETRY_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_n,
    input  logic        irdy_n,
    input  logic        idsel,
    input  logic [3:0]  cbe_n,
    input  logic [31:0] ad_in,
    input  logic        card_hit,
    input  logic        user_ready,
    output logic [31:0] addr,
    output logic [3:0]  cmd,
    output logic        first_cyc,
    output logic        acc_cfg,
    output logic        acc_end,
    output logic        data_xfer,
    output logic        devsel_n,
    output logic        trdy_n,
    output logic        stop_n,
    output logic        tgt_oe
);

    localparam logic [7:0] LP_THRESH = 8'(RETRY_LIMIT - 1);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [3:0]  r_cmd, w_cmd_nxt;
    logic [7:0]  r_wait, w_wait_nxt;
    logic        r_done, w_done_nxt;
    logic        r_first, w_first_nxt;
    logic        r_cfg, w_cfg_nxt;
    logic        r_end, w_end_nxt;
    logic        r_dx, w_dx_nxt;
    logic        r_devsel_n, w_devsel_nxt;
    logic        r_trdy_n, w_trdy_nxt;
    logic        r_stop_n, w_stop_nxt;
    logic        r_oe, w_oe_nxt;
    logic        w_xfer;
    logic [7:0]  w_wait_inc;

    assign w_xfer     = !irdy_n && !r_trdy_n;
    assign w_wait_inc = r_wait + 8'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_cmd_nxt    = r_cmd;
        w_wait_nxt   = r_wait;
        w_done_nxt   = r_done;
        w_first_nxt  = 1'b0;
        w_cfg_nxt    = r_cfg;
        w_end_nxt    = 1'b0;
        w_dx_nxt     = 1'b0;
        w_devsel_nxt = 1'b1;
        w_trdy_nxt   = 1'b1;
        w_stop_nxt   = 1'b1;
        w_oe_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!frame_n) begin
                    w_addr_nxt  = ad_in;
                    w_cmd_nxt   = cbe_n;
                    w_cfg_nxt   = idsel && is_cfg_cmd(cbe_n);
                    w_first_nxt = 1'b1;
                    w_wait_nxt  = 8'd0;
                    w_done_nxt  = 1'b0;
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (card_hit) begin
                    w_devsel_nxt = 1'b0;
                    w_oe_nxt     = 1'b1;
                    w_state_nxt  = ST_XFER;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_XFER: begin
                w_devsel_nxt = 1'b0;
                w_oe_nxt     = 1'b1;
                w_dx_nxt     = w_xfer;
                if (w_xfer) w_done_nxt = 1'b1;
                if (w_xfer && frame_n) begin
                    w_end_nxt    = 1'b1;
                    w_cfg_nxt    = 1'b0;
                    w_devsel_nxt = 1'b1;
                    w_state_nxt  = ST_TURNAR;
                end else begin
                    w_trdy_nxt = !user_ready;
                    // Counter saturates at the threshold; a ready backend on that edge beats the retry.
                    if (!r_done && !w_xfer && (r_wait != LP_THRESH)) begin
                        w_wait_nxt = w_wait_inc;
                        if ((w_wait_inc == LP_THRESH) && !user_ready && r_trdy_n) begin
                            w_trdy_nxt  = 1'b1;
                            w_stop_nxt  = 1'b0;
                            w_state_nxt = ST_STOP;
                        end
                    end
                end
            end
            ST_STOP: begin
                w_devsel_nxt = 1'b0;
                w_stop_nxt   = 1'b0;
                w_oe_nxt     = 1'b1;
                if (frame_n) begin
                    w_end_nxt    = 1'b1;
                    w_cfg_nxt    = 1'b0;
                    w_devsel_nxt = 1'b1;
                    w_stop_nxt   = 1'b1;
                    w_state_nxt  = ST_TURNAR;
                end
            end
            ST_TURNAR: begin
                w_state_nxt = ST_IDLE;
            end
            ST_BUSY: begin
                if (frame_n && irdy_n) begin
                    w_cfg_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= 32'd0;
            r_cmd      <= 4'd0;
            r_wait     <= 8'd0;
            r_done     <= 1'b0;
            r_first    <= 1'b0;
            r_cfg      <= 1'b0;
            r_end      <= 1'b0;
            r_dx       <= 1'b0;
            r_devsel_n <= 1'b1;
            r_trdy_n   <= 1'b1;
            r_stop_n   <= 1'b1;
            r_oe       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_cmd      <= w_cmd_nxt;
            r_wait     <= w_wait_nxt;
            r_done     <= w_done_nxt;
            r_first    <= w_first_nxt;
            r_cfg      <= w_cfg_nxt;
            r_end      <= w_end_nxt;
            r_dx       <= w_dx_nxt;
            r_devsel_n <= w_devsel_nxt;
            r_trdy_n   <= w_trdy_nxt;
            r_stop_n   <= w_stop_nxt;
            r_oe       <= w_oe_nxt;
        end
    end

    assign addr      = r_addr;
    assign cmd       = r_cmd;
    assign first_cyc = r_first;
    assign acc_cfg   = r_cfg;
    assign acc_end   = r_end;
    assign data_xfer = r_dx;
    assign devsel_n  = r_devsel_n;
    assign trdy_n    = r_trdy_n;
    assign stop_n    = r_stop_n;
    assign tgt_oe    = r_oe;

endmodule

// File: tb/tb_pci_target_seq.sv
// tb/tb_pci_target_seq.sv - scoreboard bench for pci_target_seq
module tb_pci_target_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_n, irdy_n, idsel, card_hit, user_ready;
    logic [3:0]  cbe_n;
    logic [31:0] ad_in;
    logic [31:0] addr;
    logic [3:0]  cmd;
    logic        first_cyc, acc_cfg, acc_end, data_xfer;
    logic        devsel_n, trdy_n, stop_n, tgt_oe;
    logic [7:0]  w_obs;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    pci_target_seq #(.RETRY_LIMIT(16)) dut (
        .clk(clk), .rst(rst), .frame_n(frame_n), .irdy_n(irdy_n), .idsel(idsel),
        .cbe_n(cbe_n), .ad_in(ad_in), .card_hit(card_hit), .user_ready(user_ready),
        .addr(addr), .cmd(cmd), .first_cyc(first_cyc), .acc_cfg(acc_cfg),
        .acc_end(acc_end), .data_xfer(data_xfer), .devsel_n(devsel_n),
        .trdy_n(trdy_n), .stop_n(stop_n), .tgt_oe(tgt_oe)
    );

    always #5 clk = ~clk;

    // {devsel_n, trdy_n, stop_n, tgt_oe, first_cyc, acc_cfg, acc_end, data_xfer}
    assign w_obs = {devsel_n, trdy_n, stop_n, tgt_oe, first_cyc, acc_cfg, acc_end, data_xfer};

    task automatic cyc(input logic f, input logic i, input logic u, input logic h, input logic [7:0] e);
        frame_n    = f;
        irdy_n     = i;
        user_ready = u;
        card_hit   = h;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        obs_q.push_back(w_obs);
    endtask

    task automatic test_reset();
        rst = 1'b0; frame_n = 1'b1; irdy_n = 1'b1; idsel = 1'b0; cbe_n = 4'hF;
        ad_in = 32'd0; card_hit = 1'b0; user_ready = 1'b0;
        #12;
        n_chk++;
        if (w_obs !== 8'hE0) begin n_fail++; $display("FAIL reset_outs: got %b want %b", w_obs, 8'hE0); end
        n_chk++;
        if (addr !== 32'd0 || cmd !== 4'd0) begin
            n_fail++; $display("FAIL reset_addr: got %h/%h want 0/0", addr, cmd);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cfg_read();
        logic [7:0] e, o;
        int k = 0;
        idsel = 1'b1; cbe_n = 4'b1010; ad_in = 32'h0000_0010;
        cyc(0, 1, 0, 0, 8'hEC);
        idsel = 1'b0; cbe_n = 4'h0; ad_in = 32'hDEAD_BEEF;
        cyc(1, 0, 1, 1, 8'h74);
        cyc(1, 0, 1, 0, 8'h34);
        cyc(1, 0, 1, 0, 8'hF3);
        cyc(1, 1, 0, 0, 8'hE0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL cfg_read cyc%0d: got %b want %b", k, o, e); end
            k++;
        end
        n_chk++;
        if (addr !== 32'h0000_0010 || cmd !== 4'b1010) begin
            n_fail++; $display("FAIL cfg_read_latch: got %h/%h want 00000010/a", addr, cmd);
        end
    endtask

    task automatic test_burst();
        logic [7:0] e, o;
        int k = 0;
        int n_dx = 0;
        idsel = 1'b0; cbe_n = 4'b0111; ad_in = 32'h1000_0000;
        cyc(0, 1, 0, 0, 8'hE8);
        cyc(0, 0, 1, 1, 8'h70);
        cyc(0, 0, 1, 0, 8'h30);
        cyc(0, 0, 0, 0, 8'h71);
        cyc(0, 0, 1, 0, 8'h30);
        cyc(0, 0, 0, 0, 8'h71);
        cyc(0, 0, 1, 0, 8'h30);
        cyc(0, 0, 1, 0, 8'h31);
        cyc(1, 0, 1, 0, 8'hF3);
        cyc(1, 1, 0, 0, 8'hE0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o[0]) n_dx++;
            if (o !== e) begin n_fail++; $display("FAIL burst cyc%0d: got %b want %b", k, o, e); end
            k++;
        end
        n_chk++;
        if (n_dx !== 4) begin n_fail++; $display("FAIL burst_count: got %0d want 4", n_dx); end
    endtask

    task automatic test_no_claim();
        logic [7:0] e, o;
        int k = 0;
        cbe_n = 4'b0110; ad_in = 32'h2000_0000;
        cyc(0, 1, 0, 0, 8'hE8);
        cyc(0, 0, 0, 0, 8'hE0);
        cyc(0, 0, 0, 0, 8'hE0);
        cyc(1, 0, 0, 0, 8'hE0);
        cyc(1, 1, 0, 0, 8'hE0);
        cyc(0, 1, 0, 0, 8'hE8);
        cyc(0, 0, 0, 0, 8'hE0);
        cyc(1, 1, 0, 0, 8'hE0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL no_claim cyc%0d: got %b want %b", k, o, e); end
            k++;
        end
    endtask

    task automatic test_retry();
        logic [7:0] e, o;
        int k = 0;
        cbe_n = 4'b0110; ad_in = 32'h3000_0000;
        cyc(0, 1, 0, 0, 8'hE8);
        cyc(0, 0, 0, 1, 8'h70);
        for (int c = 0; c < 14; c++) cyc(0, 0, 0, 0, 8'h70);
        cyc(0, 0, 0, 0, 8'h50);
        cyc(0, 0, 0, 0, 8'h50);
        cyc(1, 0, 0, 0, 8'hF2);
        cyc(1, 1, 0, 0, 8'hE0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL retry cyc%0d: got %b want %b", k, o, e); end
            k++;
        end
    endtask

    task automatic test_ready_at_threshold();
        logic [7:0] e, o;
        int k = 0;
        cbe_n = 4'b0110; ad_in = 32'h4000_0000;
        cyc(0, 1, 0, 0, 8'hE8);
        cyc(0, 0, 0, 1, 8'h70);
        for (int c = 0; c < 14; c++) cyc(0, 0, 0, 0, 8'h70);
        cyc(0, 0, 1, 0, 8'h30);
        cyc(1, 0, 1, 0, 8'hF3);
        cyc(1, 1, 0, 0, 8'hE0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL ready_thresh cyc%0d: got %b want %b", k, o, e); end
            k++;
        end
    endtask

    task automatic test_reset_mid_xfer();
        logic [7:0] e, o;
        int k = 0;
        cbe_n = 4'b0111; ad_in = 32'h5000_0000;
        cyc(0, 1, 0, 0, 8'hE8);
        cyc(0, 0, 1, 1, 8'h70);
        cyc(0, 0, 1, 0, 8'h30);
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if (w_obs !== 8'hE0) begin n_fail++; $display("FAIL async_reset_outs: got %b want %b", w_obs, 8'hE0); end
        n_chk++;
        if (addr !== 32'd0 || cmd !== 4'd0) begin
            n_fail++; $display("FAIL async_reset_addr: got %h/%h want 0/0", addr, cmd);
        end
        frame_n = 1'b1; irdy_n = 1'b1; user_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idsel = 1'b1; cbe_n = 4'b1011; ad_in = 32'h0000_0044;
        cyc(0, 1, 0, 0, 8'hEC);
        cyc(1, 0, 1, 1, 8'h74);
        cyc(1, 0, 1, 0, 8'h34);
        cyc(1, 0, 1, 0, 8'hF3);
        cyc(1, 1, 0, 0, 8'hE0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL reset_recover cyc%0d: got %b want %b", k, o, e); end
            k++;
        end
        n_chk++;
        if (addr !== 32'h0000_0044 || cmd !== 4'b1011) begin
            n_fail++; $display("FAIL reset_recover_latch: got %h/%h want 00000044/b", addr, cmd);
        end
    endtask

    initial begin
        test_reset();
        test_cfg_read();
        test_burst();
        test_no_claim();
        test_retry();
        test_ready_at_threshold();
        test_reset_mid_xfer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
